// File: rtl/scaler_h_mc.sv
// Horizontal bilinear scaler for CHANNELS components per pixel.
// Ping-pong line banks let output line N-1 be produced while input line N is captured.
module scaler_h_mc #(
  parameter int unsigned CHANNELS         = 1,
  parameter int unsigned PIXEL_WIDTH      = 8,
  parameter int unsigned LINE_IN_SIZE_MAX = 4096,
  parameter int unsigned SCALE_STEP       = 128,
  parameter int unsigned COE_WIDTH        = 8
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [15:0]                     reg_h_scale_step,
  input  logic [CHANNELS*PIXEL_WIDTH-1:0] di_i,
  input  logic                            de_i,
  input  logic                            hs_i,
  input  logic                            vs_i,
  output logic [CHANNELS*PIXEL_WIDTH-1:0] do_o,
  output logic                            de_o,
  output logic                            hs_o,
  output logic                            vs_o,
  output logic                            ovf_o
);

  localparam int unsigned F  = $clog2(SCALE_STEP);
  localparam int unsigned DW = CHANNELS * PIXEL_WIDTH;
  localparam int unsigned IW = $clog2(LINE_IN_SIZE_MAX);
  localparam int unsigned AW = IW + 1;
  localparam int unsigned PW = 16 + F;
  localparam int unsigned CW = COE_WIDTH + 1;
  localparam int unsigned SW = PIXEL_WIDTH + CW + 1;

  localparam logic [AW-1:0] MaxCnt    = AW'(LINE_IN_SIZE_MAX);
  localparam logic [CW-1:0] StepCoe   = CW'(SCALE_STEP);
  localparam logic [15:0]   UnityStep = 16'(SCALE_STEP);
  localparam logic [SW-1:0] Half      = SW'(SCALE_STEP / 2);

  typedef enum logic [1:0] {StIdle, StRun, StGap} state_e;

  state_e                          state_q, state_d;
  logic [AW-1:0]                   wcnt_q, wcnt_d;
  logic                            wbank_q, wbank_d;
  logic [1:0]                      full_q, full_d;
  logic [1:0][AW-1:0]              win_q, win_d;
  logic                            hs_prev_q, hs_prev_d;
  logic                            rbank_q, rbank_d;
  logic [AW-1:0]                   cur_win_q, cur_win_d;
  logic [PW-1:0]                   last_q, last_d;
  logic [15:0]                     step_q, step_d;
  logic [PW-1:0]                   acc_q, acc_d;
  logic                            gcnt_q, gcnt_d;
  logic                            v1_q, v1_d;
  logic [F-1:0]                    fr_q, fr_d;
  logic                            v2_q, v2_d;
  logic [CHANNELS-1:0][SW-1:0]     sum_q, sum_d;
  logic [DW-1:0]                   do_q, do_d;
  logic                            de_q, de_d;
  logic                            hs_q, hs_d;
  logic                            vs_q, vs_d;
  logic                            ovf_q, ovf_d;

  logic [DW-1:0] mem [2][LINE_IN_SIZE_MAX];
  logic [DW-1:0] rd_a_q, rd_b_q;

  logic          hs_rise, wr_en, release_bank, other_bank, other_busy;
  logic [IW-1:0] rd_idx, rd_idx1;
  logic [PW-1:0] acc_next;
  logic [CW-1:0] coe_a, coe_b;
  logic          sel_bank;

  assign hs_rise      = hs_i && !hs_prev_q;
  assign wr_en        = de_i && !hs_i && (wcnt_q < MaxCnt);
  assign release_bank = (state_q == StGap) && gcnt_q;
  assign other_bank   = ~wbank_q;
  // A bank freed in this very cycle counts as available for the incoming line.
  assign other_busy   = full_q[other_bank] && !(release_bank && (rbank_q == other_bank));
  assign rd_idx       = acc_q[F +: IW];
  assign rd_idx1      = (({1'b0, rd_idx} + 1'b1) < cur_win_q) ? rd_idx + 1'b1 : rd_idx;
  assign acc_next     = acc_q + PW'(step_q);
  assign coe_b        = CW'(fr_q);
  assign coe_a        = StepCoe - coe_b;
  assign sel_bank     = ~full_q[0];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wbank_q][wcnt_q[IW-1:0]] <= di_i;
    rd_a_q <= mem[rbank_q][rd_idx];
    rd_b_q <= mem[rbank_q][rd_idx1];
  end

  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    wbank_d   = wbank_q;
    full_d    = full_q;
    win_d     = win_q;
    hs_prev_d = hs_i;
    rbank_d   = rbank_q;
    cur_win_d = cur_win_q;
    last_d    = last_q;
    step_d    = step_q;
    acc_d     = acc_q;
    gcnt_d    = gcnt_q;
    ovf_d     = 1'b0;
    v1_d      = (state_q == StRun);
    fr_d      = acc_q[F-1:0];
    v2_d      = v1_q;
    de_d      = v2_q;
    hs_d      = ~v2_q;
    vs_d      = vs_q;
    sum_d     = '0;
    do_d      = '0;

    if (hs_rise) begin
      wcnt_d = '0;
    end else if (wr_en) begin
      wcnt_d = wcnt_q + 1'b1;
    end

    if (release_bank) full_d[rbank_q] = 1'b0;

    if (hs_rise && (wcnt_q != '0)) begin
      if (other_busy) begin
        ovf_d = 1'b1;
      end else begin
        full_d[wbank_q] = 1'b1;
        win_d[wbank_q]  = wcnt_q;
        wbank_d         = other_bank;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (|full_q) begin
          rbank_d   = sel_bank;
          cur_win_d = win_q[sel_bank];
          last_d    = PW'(win_q[sel_bank] - AW'(1)) << F;
          step_d    = (reg_h_scale_step == '0) ? UnityStep : reg_h_scale_step;
          acc_d     = '0;
          state_d   = StRun;
        end else if (vs_q && !vs_i && (wcnt_q == '0)) begin
          // A line still being captured keeps the frame open.
          vs_d = 1'b0;
        end
      end
      StRun: begin
        if (acc_next > last_q) begin
          state_d = StGap;
          gcnt_d  = 1'b0;
        end else begin
          acc_d = acc_next;
        end
      end
      StGap: begin
        gcnt_d = gcnt_q + 1'b1;
        if (gcnt_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (v2_q) vs_d = 1'b1;

    for (int c = 0; c < CHANNELS; c++) begin
      sum_d[c] = SW'(rd_a_q[c*PIXEL_WIDTH +: PIXEL_WIDTH]) * SW'(coe_a)
               + SW'(rd_b_q[c*PIXEL_WIDTH +: PIXEL_WIDTH]) * SW'(coe_b) + Half;
      do_d[c*PIXEL_WIDTH +: PIXEL_WIDTH] = v2_q ? sum_q[c][F +: PIXEL_WIDTH] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      wcnt_q    <= '0;
      wbank_q   <= 1'b0;
      full_q    <= '0;
      win_q     <= '0;
      hs_prev_q <= 1'b1;
      rbank_q   <= 1'b0;
      cur_win_q <= '0;
      last_q    <= '0;
      step_q    <= UnityStep;
      acc_q     <= '0;
      gcnt_q    <= 1'b0;
      v1_q      <= 1'b0;
      fr_q      <= '0;
      v2_q      <= 1'b0;
      sum_q     <= '0;
      do_q      <= '0;
      de_q      <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      wbank_q   <= wbank_d;
      full_q    <= full_d;
      win_q     <= win_d;
      hs_prev_q <= hs_prev_d;
      rbank_q   <= rbank_d;
      cur_win_q <= cur_win_d;
      last_q    <= last_d;
      step_q    <= step_d;
      acc_q     <= acc_d;
      gcnt_q    <= gcnt_d;
      v1_q      <= v1_d;
      fr_q      <= fr_d;
      v2_q      <= v2_d;
      sum_q     <= sum_d;
      do_q      <= do_d;
      de_q      <= de_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      ovf_q     <= ovf_d;
    end
  end

  assign do_o  = do_q;
  assign de_o  = de_q;
  assign hs_o  = hs_q;
  assign vs_o  = vs_q;
  assign ovf_o = ovf_q;

endmodule

// File: tb/tb_scaler_h_mc.sv
// Self-checking bench for scaler_h_mc (3 channels) against an arithmetic interpolation model.
module tb_scaler_h_mc;
  localparam int CH = 3;
  localparam int PX = 8;
  localparam int DW = CH * PX;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [15:0]   step;
  logic [DW-1:0] di;
  logic          de_i, hs_i, vs_i;
  logic [DW-1:0] do_o;
  logic          de_o, hs_o, vs_o, ovf_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int rise_cyc = 0;

  logic [DW-1:0] line_a [4100];
  logic [DW-1:0] line_b [64];

  logic [DW-1:0] out_q [$];
  int            start_q [$];
  int            ovf_cnt = 0, vs_rise = 0, hs_bad = 0;
  logic          de_prev = 1'b0, vs_prev = 1'b0;

  scaler_h_mc #(.CHANNELS(CH), .PIXEL_WIDTH(PX), .LINE_IN_SIZE_MAX(4096),
                .SCALE_STEP(128), .COE_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .reg_h_scale_step(step), .di_i(di), .de_i(de_i),
    .hs_i(hs_i), .vs_i(vs_i), .do_o(do_o), .de_o(de_o), .hs_o(hs_o), .vs_o(vs_o),
    .ovf_o(ovf_o));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (de_o === 1'b1) begin
      if (!de_prev) start_q.push_back(cyc);
      out_q.push_back(do_o);
    end
    if (hs_o !== ~de_o) hs_bad++;
    if (ovf_o === 1'b1) ovf_cnt++;
    if (vs_o === 1'b1 && !vs_prev) vs_rise++;
    de_prev = (de_o === 1'b1);
    vs_prev = (vs_o === 1'b1);
  end

  function automatic int model_nout(input int win, input int st);
    int s;
    s = (st == 0) ? 128 : st;
    return ((win - 1) * 128) / s + 1;
  endfunction

  function automatic logic [DW-1:0] model_px(input int k, input int win, input int st);
    int s, p, idx, fr, ib, a, b;
    logic [DW-1:0] r;
    s   = (st == 0) ? 128 : st;
    p   = k * s;
    idx = p / 128;
    fr  = p % 128;
    ib  = (idx + 1 < win) ? idx + 1 : win - 1;
    for (int c = 0; c < CH; c++) begin
      a = int'(line_a[idx][c*PX +: PX]);
      b = int'(line_a[ib][c*PX +: PX]);
      r[c*PX +: PX] = 8'((a * (128 - fr) + b * fr + 64) / 128);
    end
    return r;
  endfunction

  task automatic drive_line(input int n, input bit use_b);
    @(negedge clk);
    hs_i = 1'b0;
    for (int i = 0; i < n; i++) begin
      de_i = 1'b1;
      di   = use_b ? line_b[i % 64] : line_a[i];
      @(negedge clk);
    end
    de_i = 1'b0;
    di   = '0;
    hs_i = 1'b1;
    rise_cyc = cyc;
  endtask

  task automatic test_reset;
    rst_n = 1'b1; step = 16'd128; di = '0; de_i = 1'b0; hs_i = 1'b1; vs_i = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (do_o !== '0)  begin errors++; $display("FAIL reset do_o got=%h exp=0", do_o); end
    checks++; if (de_o !== 1'b0) begin errors++; $display("FAIL reset de_o got=%b exp=0", de_o); end
    checks++; if (hs_o !== 1'b1) begin errors++; $display("FAIL reset hs_o got=%b exp=1", hs_o); end
    checks++; if (vs_o !== 1'b0) begin errors++; $display("FAIL reset vs_o got=%b exp=0", vs_o); end
    checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL reset ovf_o got=%b exp=0", ovf_o); end
    rst_n = 1'b1;
    vs_i  = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_unity;
    int oq, sq;
    logic [DW-1:0] got, exp;
    for (int i = 0; i < 8; i++) line_a[i] = {16'($urandom()), 8'((i + 1) * 10)};
    oq = out_q.size(); sq = start_q.size(); step = 16'd128;
    drive_line(8, 0);
    repeat (30) @(negedge clk);
    checks++; if (out_q.size() - oq != 8) begin errors++;
      $display("FAIL unity count got=%0d exp=8", out_q.size() - oq); end
    checks++; if (start_q.size() - sq != 1) begin errors++;
      $display("FAIL unity runs got=%0d exp=1", start_q.size() - sq); end
    if (start_q.size() > sq) begin
      checks++; if (start_q[sq] - rise_cyc - 1 != 4) begin errors++;
        $display("FAIL unity latency got=%0d exp=4", start_q[sq] - rise_cyc - 1); end
    end
    for (int k = 0; k < 8 && oq + k < out_q.size(); k++) begin
      got = out_q[oq + k]; exp = model_px(k, 8, 128);
      checks++; if (got !== exp || got[7:0] !== 8'((k + 1) * 10)) begin errors++;
        $display("FAIL unity px%0d got=%h exp=%h", k, got, exp); end
    end
  endtask

  task automatic test_down2;
    int oq;
    logic [DW-1:0] got;
    for (int i = 0; i < 8; i++) line_a[i] = {16'($urandom()), 8'(i * 10)};
    oq = out_q.size(); step = 16'd256;
    drive_line(8, 0);
    repeat (30) @(negedge clk);
    checks++; if (out_q.size() - oq != 4) begin errors++;
      $display("FAIL down2 count got=%0d exp=4", out_q.size() - oq); end
    for (int k = 0; k < 4 && oq + k < out_q.size(); k++) begin
      got = out_q[oq + k];
      checks++; if (got !== model_px(k, 8, 256) || got[7:0] !== 8'(k * 20)) begin errors++;
        $display("FAIL down2 px%0d got=%h exp=%h", k, got, model_px(k, 8, 256)); end
    end
  endtask

  task automatic test_up2;
    int oq;
    logic [DW-1:0] got;
    logic [7:0] src [4];
    logic [7:0] ref8 [7];
    src  = '{8'd0, 8'd100, 8'd200, 8'd250};
    ref8 = '{8'd0, 8'd50, 8'd100, 8'd150, 8'd200, 8'd225, 8'd250};
    for (int i = 0; i < 4; i++) line_a[i] = {16'($urandom()), src[i]};
    oq = out_q.size(); step = 16'd64;
    drive_line(4, 0);
    repeat (30) @(negedge clk);
    checks++; if (out_q.size() - oq != 7) begin errors++;
      $display("FAIL up2 count got=%0d exp=7", out_q.size() - oq); end
    for (int k = 0; k < 7 && oq + k < out_q.size(); k++) begin
      got = out_q[oq + k];
      checks++; if (got !== model_px(k, 4, 64) || got[7:0] !== ref8[k]) begin errors++;
        $display("FAIL up2 px%0d got=%h exp=%h", k, got, model_px(k, 4, 64)); end
    end
  endtask

  task automatic test_rgb;
    int oq;
    logic [DW-1:0] got, exp;
    for (int i = 0; i < 5; i++) line_a[i] = {8'd0, 8'd255, 8'(i * 10)};
    oq = out_q.size(); step = 16'd192;
    drive_line(5, 0);
    repeat (30) @(negedge clk);
    checks++; if (out_q.size() - oq != 3) begin errors++;
      $display("FAIL rgb count got=%0d exp=3", out_q.size() - oq); end
    for (int k = 0; k < 3 && oq + k < out_q.size(); k++) begin
      got = out_q[oq + k];
      exp = {8'd0, 8'd255, 8'(k * 15)};
      checks++; if (got !== exp) begin errors++;
        $display("FAIL rgb px%0d got=%h exp=%h", k, got, exp); end
    end
  endtask

  task automatic test_step0;
    int oq;
    for (int i = 0; i < 10; i++) line_a[i] = DW'($urandom());
    oq = out_q.size(); step = 16'd0;
    drive_line(10, 0);
    repeat (30) @(negedge clk);
    checks++; if (out_q.size() - oq != 10) begin errors++;
      $display("FAIL step0 count got=%0d exp=10", out_q.size() - oq); end
    for (int k = 0; k < 10 && oq + k < out_q.size(); k++) begin
      checks++; if (out_q[oq + k] !== line_a[k]) begin errors++;
        $display("FAIL step0 px%0d got=%h exp=%h", k, out_q[oq + k], line_a[k]); end
    end
  endtask

  task automatic test_win0;
    int oq, sq;
    oq = out_q.size(); sq = start_q.size(); step = 16'd128;
    drive_line(0, 0);
    repeat (30) @(negedge clk);
    checks++; if (out_q.size() != oq || start_q.size() != sq) begin errors++;
      $display("FAIL win0 pixels got=%0d exp=0", out_q.size() - oq); end
  endtask

  task automatic test_random;
    int oq, win, st, n;
    for (int it = 0; it < 6; it++) begin
      win = $urandom_range(1, 40);
      st  = $urandom_range(16, 400);
      n   = model_nout(win, st);
      for (int i = 0; i < win; i++) line_a[i] = DW'($urandom());
      oq = out_q.size(); step = 16'(st);
      drive_line(win, 0);
      repeat (n + 30) @(negedge clk);
      checks++; if (out_q.size() - oq != n) begin errors++;
        $display("FAIL rand%0d count got=%0d exp=%0d", it, out_q.size() - oq, n); end
      for (int k = 0; k < n && oq + k < out_q.size(); k++) begin
        checks++; if (out_q[oq + k] !== model_px(k, win, st)) begin errors++;
          $display("FAIL rand%0d px%0d win=%0d step=%0d got=%h exp=%h", it, k, win, st,
                   out_q[oq + k], model_px(k, win, st)); end
      end
    end
  endtask

  task automatic test_overflow;
    int oq, sq, o0;
    for (int i = 0; i < 64; i++) begin line_a[i] = DW'($urandom()); line_b[i] = DW'($urandom()); end
    oq = out_q.size(); sq = start_q.size(); o0 = ovf_cnt; step = 16'd16;
    drive_line(64, 0);
    repeat (20) @(negedge clk);
    drive_line(64, 1);
    repeat (600) @(negedge clk);
    checks++; if (ovf_cnt - o0 != 1) begin errors++;
      $display("FAIL ovf pulse cycles got=%0d exp=1", ovf_cnt - o0); end
    checks++; if (out_q.size() - oq != 505 || start_q.size() - sq != 1) begin errors++;
      $display("FAIL ovf count got=%0d exp=505", out_q.size() - oq); end
    for (int k = 0; k < 505 && oq + k < out_q.size(); k++) begin
      checks++; if (out_q[oq + k] !== model_px(k, 64, 16)) begin errors++;
        $display("FAIL ovf px%0d got=%h exp=%h", k, out_q[oq + k], model_px(k, 64, 16)); end
    end
  endtask

  task automatic test_maxline;
    int oq;
    for (int i = 0; i < 4100; i++) line_a[i] = DW'($urandom());
    oq = out_q.size(); step = 16'd4096;
    drive_line(4100, 0);
    repeat (200) @(negedge clk);
    checks++; if (out_q.size() - oq != 128) begin errors++;
      $display("FAIL maxline count got=%0d exp=128", out_q.size() - oq); end
    for (int k = 0; k < 128 && oq + k < out_q.size(); k++) begin
      checks++; if (out_q[oq + k] !== model_px(k, 4096, 4096)) begin errors++;
        $display("FAIL maxline px%0d got=%h exp=%h", k, out_q[oq + k], model_px(k, 4096, 4096)); end
    end
  endtask

  task automatic test_reset_mid;
    int oq, w;
    for (int i = 0; i < 64; i++) line_a[i] = DW'($urandom());
    oq = out_q.size(); step = 16'd16;
    drive_line(64, 0);
    w = 0;
    while (out_q.size() < oq + 10 && w < 200) begin @(negedge clk); w++; end
    checks++; if (out_q.size() < oq + 10) begin errors++;
      $display("FAIL rstmid start got=%0d exp>=10", out_q.size() - oq); end
    rst_n = 1'b0;
    #1;
    checks++; if (de_o !== 1'b0 || hs_o !== 1'b1 || vs_o !== 1'b0 || do_o !== '0) begin errors++;
      $display("FAIL rstmid outputs got de=%b hs=%b vs=%b do=%h exp de=0 hs=1 vs=0 do=0",
               de_o, hs_o, vs_o, do_o); end
    oq = out_q.size();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (600) @(negedge clk);
    checks++; if (out_q.size() != oq) begin errors++;
      $display("FAIL rstmid residual got=%0d exp=0", out_q.size() - oq); end
  endtask

  task automatic test_frames;
    int oq, v0;
    vs_i = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (vs_o !== 1'b0) begin errors++; $display("FAIL frames idle vs_o got=%b exp=0", vs_o); end
    v0 = vs_rise; step = 16'd128;
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) line_a[i] = DW'($urandom());
      oq = out_q.size();
      vs_i = 1'b1;
      drive_line(8, 0);
      repeat (20) @(negedge clk);
      drive_line(8, 0);
      vs_i = 1'b0;
      repeat (40) @(negedge clk);
      checks++; if (out_q.size() - oq != 16) begin errors++;
        $display("FAIL frame%0d count got=%0d exp=16", f, out_q.size() - oq); end
      for (int k = 0; k < 16 && oq + k < out_q.size(); k++) begin
        checks++; if (out_q[oq + k] !== line_a[k % 8]) begin errors++;
          $display("FAIL frame%0d px%0d got=%h exp=%h", f, k, out_q[oq + k], line_a[k % 8]); end
      end
      checks++; if (vs_o !== 1'b0) begin errors++;
        $display("FAIL frame%0d vs_o end got=%b exp=0", f, vs_o); end
    end
    checks++; if (vs_rise - v0 != 2) begin errors++;
      $display("FAIL frames vs pulses got=%0d exp=2", vs_rise - v0); end
    checks++; if (hs_bad != 0) begin errors++;
      $display("FAIL hs_o vs de_o mismatched cycles got=%0d exp=0", hs_bad); end
  endtask

  initial begin
    test_reset;
    test_unity;
    test_down2;
    test_up2;
    test_rgb;
    test_step0;
    test_win0;
    test_random;
    test_overflow;
    test_maxline;
    test_reset_mid;
    test_frames;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
